// File: rtl/compressed_aligner_if.sv
// compressed_aligner_if: fetch-word input, redirect and instruction output bundle of the RV32IC aligner.
interface compressed_aligner_if #(parameter int XLEN = 32);
    logic            fetch_valid;
    logic [31:0]     fetch_word;
    logic            fetch_ready;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_is_compressed;
    logic [1:0]      align_case;
    logic            instr_ready;
    modport master (
        output fetch_valid, fetch_word, redirect, redirect_pc, instr_ready,
        input  fetch_ready, instr_valid, instr, instr_pc, instr_is_compressed, align_case
    );
    modport slave (
        input  fetch_valid, fetch_word, redirect, redirect_pc, instr_ready,
        output fetch_ready, instr_valid, instr, instr_pc, instr_is_compressed, align_case
    );
endinterface

// File: rtl/compressed_aligner.sv
// compressed_aligner: realigns 32-bit fetch words into one RV32IC instruction per handshake,
// carrying a 16-bit residue across words for halfword-aligned instructions.
module compressed_aligner #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic clk,
    input logic reset_n,
    compressed_aligner_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, RESIDUE, SKIP_LO} state_t;
    state_t          state_q;
    logic [15:0]     hold_q;
    logic [XLEN-1:0] pc_q;
    logic [15:0]     lo, hi;
    logic            full_lo, full_hold, in_empty, in_res, in_skip, res_c, res_f;
    logic            valid_raw, ready_raw, fire, skip_take;
    logic [1:0]      case_raw;
    logic [31:0]     instr_raw;
    always_comb begin
        lo        = bus.fetch_word[15:0];
        hi        = bus.fetch_word[31:16];
        full_lo   = lo[1:0] == 2'b11;
        full_hold = hold_q[1:0] == 2'b11;
        in_empty  = state_q == EMPTY;
        in_res    = state_q == RESIDUE;
        in_skip   = state_q == SKIP_LO;
        res_c     = in_res & ~full_hold;
        res_f     = in_res & full_hold;
        case_raw  = in_empty ? (full_lo ? 2'b00 : 2'b01) : in_res ? (full_hold ? 2'b10 : 2'b11) : 2'b00;
        instr_raw = in_empty ? (full_lo ? bus.fetch_word : {16'h0, lo})
                  : res_f    ? {lo, hold_q}
                  : res_c    ? {16'h0, hold_q} : 32'h0;
        // a compressed residue is emitted without needing a new word
        valid_raw = res_c | ((in_empty | res_f) & bus.fetch_valid);
        ready_raw = in_skip | ((in_empty | res_f) & bus.instr_ready);
    end
    assign bus.instr_valid         = reset_n & ~bus.redirect & valid_raw;
    assign bus.fetch_ready         = reset_n & ~bus.redirect & ready_raw;
    assign bus.instr               = reset_n ? instr_raw : 32'h0;
    assign bus.align_case          = reset_n ? case_raw : 2'b00;
    assign bus.instr_is_compressed = reset_n & case_raw[0];
    assign bus.instr_pc            = reset_n ? pc_q : '0;
    assign fire                    = bus.instr_valid & bus.instr_ready;
    assign skip_take               = in_skip & bus.fetch_valid & ~bus.redirect;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RESET_PC[1] ? SKIP_LO : EMPTY;
            hold_q  <= 16'h0;
            pc_q    <= {RESET_PC[XLEN-1:1], 1'b0};
        end else if (bus.redirect) begin
            state_q <= bus.redirect_pc[1] ? SKIP_LO : EMPTY;
            hold_q  <= 16'h0;
            pc_q    <= {bus.redirect_pc[XLEN-1:1], 1'b0};
        end else if (skip_take) begin
            state_q <= RESIDUE;
            hold_q  <= hi;
        end else if (fire) begin
            state_q <= (case_raw[0] ^ case_raw[1]) ? RESIDUE : EMPTY;
            if (!res_c) hold_q <= hi;
            pc_q    <= pc_q + XLEN'(case_raw[0] ? 2 : 4);
        end
    end
endmodule

// File: tb/tb_compressed_aligner.sv
// tb_compressed_aligner: directed vector table plus reset sequences for the RV32IC aligner.
module tb_compressed_aligner;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    always #5 clk = ~clk;
    compressed_aligner_if #(.XLEN(32)) bus ();
    compressed_aligner #(.XLEN(32), .RESET_PC(32'h0)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    typedef struct {
        logic        rd;
        logic [31:0] rpc;
        logic        fv;
        logic [31:0] fw;
        logic        ir;
        logic        iv;
        logic        fr;
        logic        cd;
        logic [31:0] ins;
        logic [31:0] pc;
        logic        comp;
        logic [1:0]  cs;
    } vec_t;
    vec_t vq[$];
    function automatic vec_t mk(logic rd, logic [31:0] rpc, logic fv, logic [31:0] fw, logic ir,
                                logic iv, logic fr, logic cd, logic [31:0] ins, logic [31:0] pc,
                                logic comp, logic [1:0] cs);
        vec_t v;
        v.rd = rd; v.rpc = rpc; v.fv = fv; v.fw = fw; v.ir = ir;
        v.iv = iv; v.fr = fr; v.cd = cd; v.ins = ins; v.pc = pc; v.comp = comp; v.cs = cs;
        return v;
    endfunction
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic apply(int idx, vec_t v);
        bus.redirect = v.rd; bus.redirect_pc = v.rpc; bus.fetch_valid = v.fv;
        bus.fetch_word = v.fw; bus.instr_ready = v.ir;
        #1;
        chk($sformatf("v%0d instr_valid", idx), 32'(bus.instr_valid), 32'(v.iv));
        chk($sformatf("v%0d fetch_ready", idx), 32'(bus.fetch_ready), 32'(v.fr));
        if (v.cd) begin
            chk($sformatf("v%0d instr", idx), bus.instr, v.ins);
            chk($sformatf("v%0d instr_pc", idx), bus.instr_pc, v.pc);
            chk($sformatf("v%0d compressed", idx), 32'(bus.instr_is_compressed), 32'(v.comp));
            chk($sformatf("v%0d align_case", idx), 32'(bus.align_case), 32'(v.cs));
        end
        @(negedge clk);
    endtask
    initial begin
        //           rd  rpc           fv  fw            ir  iv  fr  cd  instr         pc            c   case
        vq.push_back(mk(0, 0,          1, 32'h00A00093, 1,  1,  1,  1, 32'h00A00093, 32'h0,       0, 2'b00));
        vq.push_back(mk(0, 0,          1, 32'h00B00113, 1,  1,  1,  1, 32'h00B00113, 32'h4,       0, 2'b00));
        vq.push_back(mk(0, 0,          1, 32'h00050505, 1,  1,  1,  1, 32'h00000505, 32'h8,       1, 2'b01));
        vq.push_back(mk(0, 0,          0, 32'h0,        1,  1,  0,  1, 32'h00000005, 32'hA,       1, 2'b11));
        vq.push_back(mk(0, 0,          1, 32'h00930001, 1,  1,  1,  1, 32'h00000001, 32'hC,       1, 2'b01));
        vq.push_back(mk(0, 0,          1, 32'h11130A00, 1,  1,  1,  1, 32'h0A000093, 32'hE,       0, 2'b10));
        vq.push_back(mk(0, 0,          1, 32'h22220505, 0,  1,  0,  1, 32'h05051113, 32'h12,      0, 2'b10));
        vq.push_back(mk(0, 0,          1, 32'h22220505, 0,  1,  0,  1, 32'h05051113, 32'h12,      0, 2'b10));
        vq.push_back(mk(0, 0,          1, 32'h22220505, 0,  1,  0,  1, 32'h05051113, 32'h12,      0, 2'b10));
        vq.push_back(mk(0, 0,          1, 32'h22220505, 1,  1,  1,  1, 32'h05051113, 32'h12,      0, 2'b10));
        vq.push_back(mk(0, 0,          0, 32'h0,        1,  1,  0,  1, 32'h00002222, 32'h16,      1, 2'b11));
        vq.push_back(mk(0, 0,          1, 32'h00770001, 1,  1,  1,  1, 32'h00000001, 32'h18,      1, 2'b01));
        vq.push_back(mk(1, 32'h102,    1, 32'hDEAD0013, 1,  0,  0,  0, 32'h0,        32'h0,       0, 2'b00));
        vq.push_back(mk(0, 0,          0, 32'h0,        1,  0,  1,  0, 32'h0,        32'h0,       0, 2'b00));
        vq.push_back(mk(0, 0,          1, 32'h12340505, 1,  0,  1,  0, 32'h0,        32'h0,       0, 2'b00));
        vq.push_back(mk(0, 0,          0, 32'h0,        1,  1,  0,  1, 32'h00001234, 32'h102,     1, 2'b11));
        vq.push_back(mk(1, 32'h106,    0, 32'h0,        1,  0,  0,  0, 32'h0,        32'h0,       0, 2'b00));
        vq.push_back(mk(0, 0,          1, 32'h00930505, 1,  0,  1,  0, 32'h0,        32'h0,       0, 2'b00));
        vq.push_back(mk(0, 0,          1, 32'h11130A00, 1,  1,  1,  1, 32'h0A000093, 32'h106,     0, 2'b10));
        vq.push_back(mk(1, 32'h201,    1, 32'h00A00093, 1,  0,  0,  0, 32'h0,        32'h0,       0, 2'b00));
        vq.push_back(mk(0, 0,          1, 32'h00A00093, 1,  1,  1,  1, 32'h00A00093, 32'h200,     0, 2'b00));
        vq.push_back(mk(0, 0,          1, 32'h00050505, 0,  1,  0,  1, 32'h00000505, 32'h204,     1, 2'b01));
        vq.push_back(mk(0, 0,          0, 32'h0,        1,  0,  1,  1, 32'h00000000, 32'h204,     1, 2'b01));
        vq.push_back(mk(1, 32'hFFFFFFFE, 0, 32'h0,      1,  0,  0,  0, 32'h0,        32'h0,       0, 2'b00));
        vq.push_back(mk(0, 0,          1, 32'h00010003, 1,  0,  1,  0, 32'h0,        32'h0,       0, 2'b00));
        vq.push_back(mk(0, 0,          0, 32'h0,        1,  1,  0,  1, 32'h00000001, 32'hFFFFFFFE, 1, 2'b11));
        vq.push_back(mk(0, 0,          1, 32'h00B00113, 1,  1,  1,  1, 32'h00B00113, 32'h0,       0, 2'b00));
        vq.push_back(mk(0, 0,          1, 32'h00930001, 1,  1,  1,  1, 32'h00000001, 32'h4,       1, 2'b01));
        bus.redirect = 0; bus.redirect_pc = 0; bus.fetch_valid = 1; bus.fetch_word = 32'h00A00093;
        bus.instr_ready = 1;
        @(negedge clk);
        #1;
        chk("rst instr_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst fetch_ready", 32'(bus.fetch_ready), 32'h0);
        chk("rst instr", bus.instr, 32'h0);
        chk("rst align_case", 32'(bus.align_case), 32'h0);
        @(negedge clk);
        reset_n = 1;
        bus.fetch_valid = 0;
        #1;
        chk("post-rst instr_valid", 32'(bus.instr_valid), 32'h0);
        chk("post-rst pc", bus.instr_pc, 32'h0);
        @(negedge clk);
        foreach (vq[i]) apply(i, vq[i]);
        // residue 0x0093 is now held at pc 6; reset must discard it
        bus.fetch_valid = 1; bus.fetch_word = 32'h11130A00; bus.instr_ready = 1;
        #1;
        chk("pre-reset case", 32'(bus.align_case), 32'h2);
        reset_n = 0;
        #1;
        chk("mid-rst instr_valid", 32'(bus.instr_valid), 32'h0);
        chk("mid-rst fetch_ready", 32'(bus.fetch_ready), 32'h0);
        chk("mid-rst instr", bus.instr, 32'h0);
        chk("mid-rst align_case", 32'(bus.align_case), 32'h0);
        @(negedge clk);
        reset_n = 1;
        bus.fetch_valid = 0;
        #1;
        chk("after-rst instr_valid", 32'(bus.instr_valid), 32'h0);
        chk("after-rst pc", bus.instr_pc, 32'h0);
        @(negedge clk);
        apply(100, mk(0, 0, 1, 32'h00050505, 1, 1, 1, 1, 32'h00000505, 32'h0, 1, 2'b01));
        apply(101, mk(0, 0, 0, 32'h0, 1, 1, 0, 1, 32'h00000005, 32'h2, 1, 2'b11));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
